instr_fetch: RTL
================

// Module: instr_fetch
// PURPOSE
// - Instruction fetch stage, directly upstream of the decode/control stage.
// - Owns the PC and issues one request at a time to instruction memory.
// - Registers the returned word and presents instr/pc/pc_four with a valid/ready handshake.
// - Applies the redirect (taken branch/JAL/JALR target from the ALU) when the consumer accepts.
// PARAMETERS
// - RESET_PC  32'h0000_0000  PC loaded on reset; must be word aligned
// - ADDR_W    32             PC / instruction memory address width
// PORTS
// - i_clk           in   1       clock, rising edge
// - i_rst_n         in   1       async active-low reset
// - o_imem_addr     out  ADDR_W  fetch address (= o_pc while requesting)
// - o_imem_req      out  1       one-cycle request pulse
// - i_imem_rvalid   in   1       response valid; earliest 1 cycle after req
// - i_imem_rdata    in   32      instruction word
// - o_instr         out  32      instruction to decode
// - o_pc            out  ADDR_W  PC of o_instr
// - o_pc_four       out  ADDR_W  o_pc + 4, for JAL/JALR writeback
// - o_instr_vld     out  1       o_instr/o_pc valid
// - i_instr_rdy     in   1       consumer accepts when o_instr_vld & i_instr_rdy
// - i_pc_sel        in   1       redirect request; sampled only on accept
// - i_alu_data      in   ADDR_W  redirect target
// - o_misalign      out  1       misaligned target flag (MISALIGN_TRAP_EN only, else tied 0)
// BEHAVIOUR
// - Reset (async assert, sync release): state IDLE, pc=RESET_PC, o_instr=32'h0000_0013 (NOP),
//   o_instr_vld=0, o_imem_req=0, o_imem_addr=RESET_PC, o_misalign=0.
// - FSM:
//   - IDLE -> REQ unconditionally on the next clock.
//   - REQ: o_imem_req=1 for exactly one cycle, o_imem_addr=pc; -> WAIT.
//   - WAIT: hold until i_imem_rvalid; then register rdata into o_instr, set o_instr_vld=1; -> HOLD.
//   - HOLD: outputs stable while i_instr_rdy=0.
//     - On accept: pc <= i_pc_sel ? i_alu_data : pc+4; o_instr_vld <= 0; -> REQ.
// - Latency: accept to next req = 1 cycle; rvalid to o_instr_vld = 1 cycle.
//   Minimum 3 cycles per instruction with 1-cycle memory.
// - Single outstanding request. i_imem_rvalid outside WAIT is ignored, including a stale
//   response after reset.
// - i_pc_sel / i_alu_data are don't-care unless accept occurs in that cycle.
// - Arithmetic: pc+4 wraps modulo 2^ADDR_W (32'hFFFF_FFFC -> 32'h0). o_pc_four uses the same wrap.
// - Reset mid-WAIT: request abandoned, fetch restarts at RESET_PC via IDLE.
// - o_pc/o_instr never change while o_instr_vld=1 and i_instr_rdy=0.
// CONFIGURATION
// - MISALIGN_TRAP_EN defined:
//   - A redirect target with [1:0]!=0 sets o_misalign=1 and pc=target, enters ERR.
//   - ERR issues no requests and holds o_instr_vld=0 until reset.
// - MISALIGN_TRAP_EN undefined:
//   - Target bits [1:0] are forced to 0 before loading pc; o_misalign tied 0; no ERR state.
// TESTING
// - Reset release, mem latency 1, rdy=1 -> req at RESET_PC, then 0x4, 0x8;
//   o_instr_vld each 3rd cycle; o_pc_four = o_pc+4.
// - Hold i_instr_rdy=0 for 5 cycles in HOLD -> o_instr/o_pc unchanged, no new o_imem_req.
// - Accept with i_pc_sel=1, i_alu_data=0x100 -> next o_imem_addr=0x100; o_pc=0x100 on that fetch.
// - Stray i_imem_rvalid in IDLE/REQ/HOLD -> ignored; reset during WAIT, late rvalid ->
//   fetch restarts at RESET_PC, stale data never shown.
// - pc=0xFFFF_FFFC accepted with i_pc_sel=0 -> next fetch address 0x0000_0000.
// - Redirect to 0x102:
//   - MISALIGN_TRAP_EN defined: o_misalign=1, no further req.
//   - MISALIGN_TRAP_EN undefined: fetch from 0x100.

Source files
------------

// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the PC, issues one imem request at a time and presents the
// registered word to decode. Optional macro MISALIGN_TRAP_EN traps misaligned redirects.
module instr_fetch #(
    parameter int unsigned         ADDR_W   = 32,
    parameter logic [ADDR_W-1:0]   RESET_PC = '0
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    output logic [ADDR_W-1:0] o_imem_addr,
    output logic              o_imem_req,
    input  logic              i_imem_rvalid,
    input  logic [31:0]       i_imem_rdata,
    output logic [31:0]       o_instr,
    output logic [ADDR_W-1:0] o_pc,
    output logic [ADDR_W-1:0] o_pc_four,
    output logic              o_instr_vld,
    input  logic              i_instr_rdy,
    input  logic              i_pc_sel,
    input  logic [ADDR_W-1:0] i_alu_data,
    output logic              o_misalign
);

    localparam logic [31:0]       Nop    = 32'h0000_0013;
    localparam logic [ADDR_W-1:0] PcStep = ADDR_W'(4);

    typedef enum logic [2:0] {StIdle, StReq, StWait, StHold, StErr} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [31:0]       instr_q, instr_d;
    logic              vld_q, vld_d;

`ifdef MISALIGN_TRAP_EN
    logic misalign_q, misalign_d;
`else
    // Target low bits are discarded when the trap is compiled out.
    logic unused_alu_lsb;
    assign unused_alu_lsb = ^i_alu_data[1:0];
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= StIdle;
            pc_q    <= RESET_PC;
            instr_q <= Nop;
            vld_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            vld_q   <= vld_d;
        end
    end

`ifdef MISALIGN_TRAP_EN
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            misalign_q <= 1'b0;
        end else begin
            misalign_q <= misalign_d;
        end
    end
`endif

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        vld_d   = vld_q;
`ifdef MISALIGN_TRAP_EN
        misalign_d = misalign_q;
`endif
        unique case (state_q)
            StIdle: state_d = StReq;
            StReq:  state_d = StWait;
            StWait: begin
                if (i_imem_rvalid) begin
                    instr_d = i_imem_rdata;
                    vld_d   = 1'b1;
                    state_d = StHold;
                end
            end
            StHold: begin
                if (i_instr_rdy) begin
                    vld_d   = 1'b0;
                    state_d = StReq;
                    if (i_pc_sel) begin
`ifdef MISALIGN_TRAP_EN
                        pc_d = i_alu_data;
                        if (i_alu_data[1:0] != 2'b00) begin
                            misalign_d = 1'b1;
                            state_d    = StErr;
                        end
`else
                        pc_d = {i_alu_data[ADDR_W-1:2], 2'b00};
`endif
                    end else begin
                        pc_d = pc_q + PcStep;
                    end
                end
            end
`ifdef MISALIGN_TRAP_EN
            // Sticky until reset: no requests, nothing valid.
            StErr:   state_d = StErr;
`endif
            default: state_d = StIdle;
        endcase
    end

    assign o_imem_req  = (state_q == StReq);
    assign o_imem_addr = pc_q;
    assign o_pc        = pc_q;
    assign o_pc_four   = pc_q + PcStep;
    assign o_instr     = instr_q;
    assign o_instr_vld = vld_q;
`ifdef MISALIGN_TRAP_EN
    assign o_misalign  = misalign_q;
`else
    assign o_misalign  = 1'b0;
`endif

endmodule
